// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the write-back queue and the register file.
package regfile_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int RD_DEPTH   = 2;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/wbq_bypass_match.sv
// One read port's bypass search: youngest valid candidate whose address matches rr.
module wbq_bypass_match
  import regfile_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NC = 5
) (
  input  logic [AW-1:0]    rr,
  input  logic [NC-1:0]    cand_valid,
  input  logic [NC*AW-1:0] cand_addr,
  input  logic [NC*DW-1:0] cand_data,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic          hit_s;
  logic [DW-1:0] data_s;

  // Candidates are ordered oldest first, so the last match seen is the youngest.
  always_comb begin
    hit_s  = 1'b0;
    data_s = '0;
    for (int k = 0; k < NC; k++) begin
      if (cand_valid[k] && (cand_addr[k*AW +: AW] == rr) && (rr != AW'(ZERO_REG))) begin
        hit_s  = 1'b1;
        data_s = cand_data[k*DW +: DW];
      end else begin
        hit_s  = hit_s;
        data_s = data_s;
      end
    end
  end

  assign hit  = hit_s;
  assign data = data_s;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of a register file write port, with per-read-port bypass
// of pending writes (queue entries plus the registered output stage).
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int RD_DEPTH   = regfile_pkg::RD_DEPTH,
  parameter int Q_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           stall,
  output logic                           wr,
  output logic [ADDR_WIDTH-1:0]          rw,
  output logic [DATA_WIDTH-1:0]          d,
  input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
  output logic [RD_DEPTH-1:0]            byp_hit,
  output logic [DATA_WIDTH*RD_DEPTH-1:0] byp_data,
  output logic [$clog2(Q_DEPTH):0]       count
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NC    = Q_DEPTH + 1;

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q [Q_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [Q_DEPTH];
  logic [DATA_WIDTH-1:0] data_q [Q_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [Q_DEPTH];
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] rw_q, rw_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;

  logic full_s, empty_s, push_s, pop_s;

  assign full_s  = (count_q == CNT_W'(Q_DEPTH));
  assign empty_s = (count_q == '0);
  // Writes to the zero register are accepted but never stored.
  assign push_s  = in_valid && !full_s && (in_addr != ADDR_WIDTH'(ZERO_REG));
  assign pop_s   = !empty_s && !stall;

  // Next-state for pointers, storage, occupancy and the output stage.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    d_d     = d_q;
    if (push_s) begin
      addr_d[tail_q] = in_addr;
      data_d[tail_q] = in_data;
      tail_d         = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      wr_d   = 1'b1;
      rw_d   = addr_q[head_q];
      d_d    = data_q[head_q];
      head_d = head_q + PTR_W'(1);
    end else begin
      wr_d = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output-stage registers; reset wins over any push or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wr_q    <= 1'b0;
      rw_q    <= '0;
      d_q     <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      d_q     <= d_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign in_ready = !full_s;
  assign wr       = wr_q;
  assign rw       = rw_q;
  assign d        = d_q;
  assign count    = count_q;

  logic [NC-1:0]            cand_valid_s;
  logic [NC*ADDR_WIDTH-1:0] cand_addr_s;
  logic [NC*DATA_WIDTH-1:0] cand_data_s;
  logic [PTR_W-1:0]         idx_s;

  // Age-ordered candidate list: output stage first, then queue from head to tail-1.
  always_comb begin
    cand_valid_s                 = '0;
    cand_addr_s                  = '0;
    cand_data_s                  = '0;
    idx_s                        = head_q;
    cand_valid_s[0]              = wr_q;
    cand_addr_s[0 +: ADDR_WIDTH] = rw_q;
    cand_data_s[0 +: DATA_WIDTH] = d_q;
    for (int k = 0; k < Q_DEPTH; k++) begin
      idx_s                                  = head_q + PTR_W'(k);
      cand_valid_s[k+1]                      = (CNT_W'(k) < count_q);
      cand_addr_s[(k+1)*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[idx_s];
      cand_data_s[(k+1)*DATA_WIDTH +: DATA_WIDTH] = data_q[idx_s];
    end
  end

  for (genvar i = 0; i < RD_DEPTH; i++) begin : g_port
    wbq_bypass_match #(
      .DW (DATA_WIDTH),
      .AW (ADDR_WIDTH),
      .NC (NC)
    ) u_match (
      .rr         (rr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .cand_valid (cand_valid_s),
      .cand_addr  (cand_addr_s),
      .cand_data  (cand_data_s),
      .hit        (byp_hit[i]),
      .data       (byp_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed + random-stall bench for regfile_wb_queue; a negedge monitor checks every
// wr pulse against a scoreboard of expected writes in acceptance order.
module tb_regfile_wb_queue;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RD = 2;
  localparam int QD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_addr;
  logic [DW-1:0]    in_data;
  logic             stall;
  logic             wr;
  logic [AW-1:0]    rw;
  logic [DW-1:0]    d;
  logic [AW*RD-1:0] rr;
  logic [RD-1:0]    byp_hit;
  logic [DW*RD-1:0] byp_data;
  logic [2:0]       count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] v;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad   = 0;

  regfile_wb_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_DEPTH(RD), .Q_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .stall(stall), .wr(wr), .rw(rw), .d(d), .rr(rr),
    .byp_hit(byp_hit), .byp_data(byp_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every wr pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    wr_t e;
    if (wr === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got rw=%0d d=%h expected no write", rw, d);
      end else begin
        e = sb.pop_front();
        if (rw !== e.a || d !== e.v) begin
          bad++;
          $display("FAIL wr_order: got rw=%0d d=%h expected rw=%0d d=%h", rw, d, e.a, e.v);
        end
      end
    end
  end

  // Called at a negedge; waits (bounded) for in_ready, offers one write for one cycle.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] v, input bit rnd);
    int n = 0;
    while (!in_ready && n < 200) begin
      if (rnd) stall = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1");
    end else begin
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = v;
      if (a != '0) sb.push_back({a, v});
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; stall = 1'b0; rr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_rw", 64'(rw), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_byp_hit", 64'(byp_hit), 64'd0);

    // Single write, one-cycle latency, visible to bypass only after acceptance.
    rr = {5'd0, 5'd27};
    in_valid = 1'b1; in_addr = 5'd27; in_data = 32'hdcaf484c;
    sb.push_back({5'd27, 32'hdcaf484c});
    #1 chk("s1_no_cut_through_byp", 64'(byp_hit), 64'd0);
    chk("s1_no_cut_through_wr", 64'(wr), 64'd0);
    @(negedge clk); in_valid = 1'b0;
    chk("s1_wr_low_after_accept", 64'(wr), 64'd0);
    chk("s1_count_1", 64'(count), 64'd1);
    chk("s1_byp_queue", 64'(byp_hit), 64'd1);
    @(negedge clk);
    chk("s1_wr_high", 64'(wr), 64'd1);
    chk("s1_rw", 64'(rw), 64'd27);
    chk("s1_d", 64'(d), 64'hdcaf484c);
    chk("s1_count_0", 64'(count), 64'd0);
    chk("s1_byp_out_stage", 64'(byp_data), {32'h0, 32'hdcaf484c});
    @(negedge clk);
    chk("s1_wr_one_cycle", 64'(wr), 64'd0);
    chk("s1_byp_gone", 64'(byp_hit), 64'd0);

    // Zero-register write is discarded.
    push(5'd0, 32'h37373737, 1'b0);
    chk("s2_count", 64'(count), 64'd0);
    @(negedge clk);
    chk("s2_count_later", 64'(count), 64'd0);
    chk("s2_no_wr", 64'(wr), 64'd0);

    // Fill under stall, then drain in order on consecutive cycles.
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(AW'(i), 32'ha0000000 + 32'(i), 1'b0);
    chk("s3_count_full", 64'(count), 64'd4);
    chk("s3_in_ready_full", 64'(in_ready), 64'd0);
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("s3_wr_burst", 64'(wr), 64'd1);
      chk("s3_rw_order", 64'(rw), 64'(i));
    end
    @(negedge clk);
    chk("s3_wr_end", 64'(wr), 64'd0);
    chk("s3_count_end", 64'(count), 64'd0);

    // Youngest-match bypass across queue and output stage.
    stall = 1'b1;
    push(5'd4, 32'h11111111, 1'b0);
    push(5'd4, 32'h37373737, 1'b0);
    rr = {5'd4, 5'd4};
    #1 chk("s4_hit_both", 64'(byp_hit), 64'd3);
    chk("s4_data_both", 64'(byp_data), {32'h37373737, 32'h37373737});
    rr = {5'd4, 5'd0};
    #1 chk("s4_port0_zero_hit", 64'(byp_hit), 64'd2);
    chk("s4_port0_zero_data", 64'(byp_data), {32'h37373737, 32'h0});
    rr = {5'd7, 5'd0};
    #1 chk("s4_no_match", 64'(byp_hit), 64'd0);
    chk("s4_no_match_data", 64'(byp_data), 64'd0);
    rr = {5'd4, 5'd4};
    stall = 1'b0;
    @(negedge clk);
    chk("s4_mixed_d", 64'(d), 64'h11111111);
    chk("s4_mixed_byp", 64'(byp_data), {32'h37373737, 32'h37373737});
    @(negedge clk);
    chk("s4_out_stage_byp", 64'(byp_data), {32'h37373737, 32'h37373737});
    chk("s4_out_stage_hit", 64'(byp_hit), 64'd3);
    @(negedge clk);
    chk("s4_drained_hit", 64'(byp_hit), 64'd0);

    // Reset mid-operation, with a push offered during the reset cycle.
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) push(AW'(i), 32'hb0000000 + 32'(i), 1'b0);
    chk("s5_count_3", 64'(count), 64'd3);
    rr = {5'd2, 5'd5};
    rst = 1'b1; in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h55555555;
    sb.delete();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("s5_wr", 64'(wr), 64'd0);
    chk("s5_count", 64'(count), 64'd0);
    chk("s5_in_ready", 64'(in_ready), 64'd1);
    chk("s5_byp_hit", 64'(byp_hit), 64'd0);
    stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("s5_count_later", 64'(count), 64'd0);

    // Random stall with 100 pushes; the monitor checks order, loss and duplication.
    rr = '0;
    for (int i = 0; i < 100; i++) begin
      stall = 1'($urandom_range(0, 1));
      push(AW'($urandom_range(0, 31)), $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    stall = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("s6_drained", 64'(sb.size()), 64'd0);
    chk("s6_count", 64'(count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
